mem_arb_ctrl: RTL and testbench

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

---
 rtl/mem_arb_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_ctrl.sv
// Multi-port arbiter that serialises one granted load/store into byte-wide memory accesses.
// Load done at G+2+L, store done at G+1+L plus IO-stall cycles; rdy_in low freezes all state.
module mem_arb_ctrl #(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 1,
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [NUM_PORTS-1:0]   req_wr,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  input  logic [NUM_PORTS*3-1:0] req_len,
  input  logic [NUM_PORTS*32-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0]   flush_in,
  output logic [NUM_PORTS-1:0]   gnt,
  output logic [NUM_PORTS-1:0]   done,
  output logic [31:0]            rdata,
  output logic                   busy,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [2:0] MAXB = 3'(MAX_BYTES);
  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, owner_q, sel_idx;
  logic            sel_vld, sel_wr, own_flush;
  logic [31:0]     addr_q, wdata_q, rdata_q, sel_addr, sel_wdata;
  logic [2:0]      len_q, cnt_q, cnt_d, sel_lraw, sel_len;
  logic            resume_q, capture, io_stall;
  logic [NUM_PORTS-1:0] elig;

  assign elig = req_valid & ~flush_in;

  // Round-robin: ports above the last grant first, then wrap to the low ports.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    if (ARB_MODE == 0) begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (!sel_vld && elig[p]) begin
          sel_vld = 1'b1;
          sel_idx = PW'(p);
        end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (!sel_vld && elig[p] && (PW'(p) > rr_ptr_q)) begin
          sel_vld = 1'b1;
          sel_idx = PW'(p);
        end
      for (int p = 0; p < NUM_PORTS; p++)
        if (!sel_vld && elig[p] && (PW'(p) <= rr_ptr_q)) begin
          sel_vld = 1'b1;
          sel_idx = PW'(p);
        end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_lraw  = '0;
    sel_wr    = 1'b0;
    own_flush = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PW'(p) == sel_idx) begin
        sel_addr  = req_addr[p*32 +: 32];
        sel_wdata = req_wdata[p*32 +: 32];
        sel_lraw  = req_len[p*3 +: 3];
        sel_wr    = req_wr[p];
      end
      if (PW'(p) == owner_q) own_flush = flush_in[p];
    end
  end

  assign sel_len = (sel_lraw == 3'd0 || sel_lraw > MAXB) ? MAXB : sel_lraw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt      = '0;
    done     = '0;
    mem_wr   = 1'b0;
    capture  = 1'b0;
    io_stall = 1'b0;
    mem_a    = addr_q + 32'(cnt_q);
    mem_dout = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt     = ONE << sel_idx;
          state_d = sel_wr ? WRITE : READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (own_flush) begin
          state_d = IDLE;
        end else if (resume_q && cnt_q != 3'd0) begin
          // The response to byte cnt_q-1 arrived during the pause and was lost.
          mem_a = addr_q + 32'(cnt_q) - 32'd1;
        end else begin
          capture = (cnt_q != 3'd0);
          if (cnt_q == len_q) state_d = DONE;
          else                cnt_d   = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        io_stall = io_buffer_full && (mem_a[17:16] == 2'b11);
        mem_wr   = !io_stall;
        if (!io_stall) begin
          if (cnt_q == len_q - 3'd1) state_d = DONE;
          else                       cnt_d   = cnt_q + 3'd1;
        end
      end
      DONE: begin
        if (!own_flush) done = ONE << owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rdy_in) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_wr  = 1'b0;
      done    = '0;
      gnt     = '0;
      capture = 1'b0;
    end
    if (!rst_in) gnt = '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= PW'(NUM_PORTS - 1);
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      len_q    <= '0;
      resume_q <= 1'b0;
    end else begin
      resume_q <= !rdy_in;
      if (rdy_in) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (state_q == IDLE && sel_vld) begin
          owner_q  <= sel_idx;
          rr_ptr_q <= sel_idx;
          addr_q   <= sel_addr;
          wdata_q  <= sel_wdata;
          len_q    <= sel_len;
          rdata_q  <= '0;
        end
        if (capture) begin
          case (cnt_q)
            3'd1:    rdata_q[7:0]   <= mem_din;
            3'd2:    rdata_q[15:8]  <= mem_din;
            3'd3:    rdata_q[23:16] <= mem_din;
            3'd4:    rdata_q[31:24] <= mem_din;
            default: ;
          endcase
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: directed scenarios plus randomized single transactions checked
// against a transaction-level model of the byte sequence, stall rule and done timing.
module tb_mem_arb_ctrl;
  localparam int NP = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, rdy_in, io_buffer_full;
  logic [NP-1:0] req_valid, req_wr, flush_in;
  logic [NP*32-1:0] req_addr, req_wdata;
  logic [NP*3-1:0] req_len;
  logic [7:0] mem_din, mem_din_fp;

  logic [NP-1:0] gnt, done, gnt_fp, done_fp;
  logic [31:0] rdata, rdata_fp, mem_a, mem_a_fp;
  logic [7:0] mem_dout, mem_dout_fp;
  logic busy, busy_fp, mem_wr, mem_wr_fp;

  int n_checks = 0;
  int n_fail = 0;

  mem_arb_ctrl #(.NUM_PORTS(NP), .ARB_MODE(1), .MAX_BYTES(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .flush_in(flush_in),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full));

  mem_arb_ctrl #(.NUM_PORTS(NP), .ARB_MODE(0), .MAX_BYTES(4)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .flush_in(flush_in),
    .gnt(gnt_fp), .done(done_fp), .rdata(rdata_fp), .busy(busy_fp), .mem_din(mem_din_fp),
    .mem_dout(mem_dout_fp), .mem_a(mem_a_fp), .mem_wr(mem_wr_fp), .io_buffer_full(io_buffer_full));

  // Memory contents as a pure function of address; 0x100..0x103 hold 11 22 33 44.
  function automatic logic [7:0] mem_val(input logic [31:0] a);
    logic [7:0] lo;
    lo = {6'd0, a[1:0]} + 8'd1;
    return 8'(8'h11 * lo) + {a[7:2], 2'b00} + (a[15:8] - 8'd1) + a[31:24];
  endfunction

  function automatic int eff_len(input logic [2:0] l);
    if (l == 3'd0 || l > 3'd4) return 4;
    return int'(l);
  endfunction

  // Synchronous memory: one cycle from address to data.
  always @(posedge clk_in) begin
    mem_din    <= mem_val(mem_a);
    mem_din_fp <= mem_val(mem_a_fp);
  end

  task automatic idle_inputs();
    rdy_in = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0;
    req_wdata = '0; flush_in = '0; io_buffer_full = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic start_req(input int p, input bit wr, input logic [31:0] addr, input logic [2:0] len,
                           input logic [31:0] wdata);
    req_valid = '0; req_valid[p] = 1'b1; req_wr[p] = wr; req_addr[p*32 +: 32] = addr;
    req_len[p*3 +: 3] = len; req_wdata[p*32 +: 32] = wdata; io_buffer_full = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    idle_inputs();
    req_valid = '1; req_wdata = '1; req_addr = {32'h0003_0000, 32'h0000_1234};
    repeat (2) @(negedge clk_in);
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
    n_checks++; if (gnt_fp !== 2'b00) begin n_fail++; $display("FAIL rst_gnt_fp: got %b expected 00", gnt_fp); end
    n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL rst_done: got %b expected 00", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr: got %b expected 0", mem_wr); end
    n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_mem_a: got %h expected 0", mem_a); end
    n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL rst_mem_dout: got %h expected 0", mem_dout); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    @(negedge clk_in);
    req_valid = '0;
    rst_in = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
  endtask

  // One isolated transaction; full_mode 0 = never full, 1 = random, 2 = full for the first 3 cycles.
  task automatic run_txn(input int p, input bit wr, input logic [31:0] addr, input logic [2:0] len,
                         input logic [31:0] wdata, input int full_mode, input string nm);
    int L, i;
    bit stall, fin, done_seen;
    logic [NP-1:0] eg;
    logic [31:0] exp_rd, cur;
    L = eff_len(len);
    eg = '0; eg[p] = 1'b1;
    exp_rd = '0;
    for (int k = 0; k < L; k++) exp_rd[8*k +: 8] = mem_val(addr + 32'(k));
    @(negedge clk_in);
    start_req(p, wr, addr, len, wdata);
    #1;
    n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL %s gnt: got %b expected %b", nm, gnt, eg); end
    i = 0; fin = 1'b0; done_seen = 1'b0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      @(negedge clk_in);
      req_valid = '0;
      io_buffer_full = (full_mode == 1) ? 1'($urandom_range(0, 1)) : (full_mode == 2 && c <= 3);
      #1;
      if (!wr) begin
        if (c <= L) begin
          n_checks++; if (mem_a !== addr + 32'(c - 1)) begin n_fail++; $display("FAIL %s rd_addr c%0d: got %h expected %h", nm, c, mem_a, addr + 32'(c - 1)); end
          n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL %s rd_mem_wr c%0d: got %b expected 0", nm, c, mem_wr); end
        end
        if (c <= L + 1) begin
          n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL %s early_done c%0d: got %b expected 00", nm, c, done); end
        end else if (c == L + 2) begin
          n_checks++; if (done !== eg) begin n_fail++; $display("FAIL %s rd_done: got %b expected %b", nm, done, eg); end
          n_checks++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL %s rdata: got %h expected %h", nm, rdata, exp_rd); end
        end else begin
          n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s rd_idle: got busy %b expected 0", nm, busy); end
          fin = 1'b1;
        end
      end else begin
        if (i < L) begin
          cur = addr + 32'(i);
          stall = io_buffer_full && (cur[17:16] == 2'b11);
          n_checks++; if (mem_wr !== !stall) begin n_fail++; $display("FAIL %s wr_en c%0d: got %b expected %b", nm, c, mem_wr, !stall); end
          if (!stall) begin
            n_checks++; if (mem_a !== cur) begin n_fail++; $display("FAIL %s wr_addr c%0d: got %h expected %h", nm, c, mem_a, cur); end
            n_checks++; if (mem_dout !== wdata[8*i +: 8]) begin n_fail++; $display("FAIL %s wr_data c%0d: got %h expected %h", nm, c, mem_dout, wdata[8*i +: 8]); end
            i++;
          end
          n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL %s wr_early_done c%0d: got %b expected 00", nm, c, done); end
        end else if (!done_seen) begin
          n_checks++; if (done !== eg) begin n_fail++; $display("FAIL %s wr_done c%0d: got %b expected %b", nm, c, done, eg); end
          done_seen = 1'b1;
        end else begin
          n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s wr_idle: got busy %b expected 0", nm, busy); end
          fin = 1'b1;
        end
      end
    end
    io_buffer_full = 1'b0;
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no completion within 60 cycles expected completion", nm);
    end
  endtask

  task automatic test_read_basic();
    run_txn(1, 1'b0, 32'h0000_0100, 3'd4, 32'h0, 0, "ld_p1_0x100");
  endtask

  task automatic test_io_write();
    run_txn(0, 1'b1, 32'h0003_0000, 3'd2, 32'hAABB_CCDD, 2, "st_io");
  endtask

  task automatic test_len_bounds();
    run_txn(0, 1'b0, 32'h0000_0A40, 3'd0, 32'h0, 0, "ld_len0");
    run_txn(1, 1'b1, 32'h0000_0B00, 3'd7, 32'h1234_5678, 0, "st_len7");
    run_txn(1, 1'b0, 32'h0000_0C00, 3'd3, 32'h0, 0, "ld_len3");
    run_txn(0, 1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0, 0, "ld_wrap");
    run_txn(0, 1'b1, 32'hFFFF_FFFF, 3'd2, 32'hCAFE_BEEF, 0, "st_wrap");
  endtask

  task automatic test_flush_read();
    @(negedge clk_in);
    start_req(0, 1'b0, 32'h0000_2000, 3'd4, 32'h0);
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL fl_gnt: got %b expected 01", gnt); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_in);
      req_valid = '0;
      flush_in = (c == 2) ? 2'b01 : 2'b00;
      #1;
      n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL fl_done c%0d: got %b expected 00", c, done); end
      if (c >= 3) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_idle c%0d: got busy %b expected 0", c, busy); end
      end
    end
    flush_in = '0;
  endtask

  task automatic test_flush_done();
    @(negedge clk_in);
    start_req(1, 1'b0, 32'h0000_0040, 3'd1, 32'h0);
    #1;
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL fd_gnt: got %b expected 10", gnt); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_in);
      req_valid = '0;
      flush_in = (c == 3) ? 2'b10 : 2'b00;
      #1;
      n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL fd_done c%0d: got %b expected 00", c, done); end
      if (c == 3) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fd_busy_done: got %b expected 1", busy); end
      end
      if (c == 4) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fd_idle: got %b expected 0", busy); end
      end
    end
    flush_in = '0;
  endtask

  // Pause of 2 cycles after byte 0 was issued: done moves from G+6 to G+6+2+1 (one reissue).
  task automatic test_pause();
    logic [31:0] exp_rd;
    for (int k = 0; k < 4; k++) exp_rd[8*k +: 8] = mem_val(32'h0000_5004 + 32'(k));
    @(negedge clk_in);
    start_req(0, 1'b0, 32'h0000_5004, 3'd4, 32'h0);
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL pz_gnt: got %b expected 01", gnt); end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_in);
      req_valid = '0;
      rdy_in = !(c == 2 || c == 3);
      #1;
      n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL pz_mem_wr c%0d: got %b expected 0", c, mem_wr); end
      if (c < 9) begin
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL pz_early_done c%0d: got %b expected 00", c, done); end
      end else if (c == 9) begin
        n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL pz_done: got %b expected 01", done); end
        n_checks++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL pz_rdata: got %h expected %h", rdata, exp_rd); end
      end else begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pz_idle: got %b expected 0", busy); end
      end
    end
    rdy_in = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_in);
    start_req(0, 1'b0, 32'h0000_0600, 3'd4, 32'h0);
    @(negedge clk_in);
    req_valid = '0;
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
    n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL rm_mem_a: got %h expected 0", mem_a); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h expected 0", rdata); end
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      #1;
      n_checks++; if (done !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_after c%0d: got done %b busy %b expected 00 0", c, done, busy); end
    end
  endtask

  // Both ports request forever: round robin alternates from port 0, fixed priority only port 0.
  task automatic test_arbitration();
    int last, ng, nfp, e;
    logic [NP-1:0] eg;
    do_reset();
    @(negedge clk_in);
    req_valid = 2'b11; req_wr = 2'b00; req_len = {3'd1, 3'd1};
    req_addr = {32'h0000_0810, 32'h0000_0800};
    last = NP - 1; ng = 0; nfp = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (c > 0) @(negedge clk_in);
      #1;
      if (gnt !== 2'b00) begin
        e = (last + 1) % NP;
        eg = '0; eg[e] = 1'b1;
        n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt #%0d: got %b expected %b", ng, gnt, eg); end
        last = e;
        ng++;
      end
      if (gnt_fp !== 2'b00) begin
        n_checks++; if (gnt_fp !== 2'b01) begin n_fail++; $display("FAIL fp_gnt: got %b expected 01", gnt_fp); end
        nfp++;
      end
    end
    n_checks++; if (ng < 4) begin n_fail++; $display("FAIL rr_timeout: got %0d grants expected 4", ng); end
    n_checks++; if (nfp < 3) begin n_fail++; $display("FAIL fp_count: got %0d grants expected at least 3", nfp); end
    @(negedge clk_in);
    req_valid = '0;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic test_random();
    logic [31:0] addr, r;
    for (int t = 0; t < 24; t++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: addr = r;
        1: addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        2: addr = r | 32'h0003_0000;
        default: addr = 32'h0003_FFFC + 32'($urandom_range(0, 3));
      endcase
      run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), addr, 3'($urandom_range(0, 7)),
              $urandom, 1, "rand");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_io_write();
    test_len_bounds();
    test_flush_read();
    test_flush_done();
    test_pause();
    test_reset_mid();
    test_arbitration();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
